// File: rtl/ides_word_align_pkg.sv
// Shared types and constants for the IDES8 word-alignment controller.
// Holds the FSM encoding, default training word and counter widths.
package ides_align_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WAIT   = 3'd1,
      ST_CHECK  = 3'd2,
      ST_SLIP   = 3'd3,
      ST_LOCKED = 3'd4,
      ST_FAIL   = 3'd5
   } align_state_e;

   localparam logic [7:0] TRAIN_PATTERN_DEF = 8'hF0;

   localparam int WAIT_CNT_W    = 4;
   localparam int MATCH_CNT_W   = 8;
   localparam int ATTEMPT_CNT_W = 4;

   // Rotate a deserializer word left by n bit positions.
   function automatic logic [7:0] rotl8(input logic [7:0] w, input logic [2:0] n);
      logic [15:0] d;
      d = {w, w} << n;
      return d[15:8];
   endfunction

endpackage

// File: rtl/ides_word_align_if.sv
// Word-alignment bus between the IDES8 deserializer, the aligner and its consumer.
// slave is the aligner's view; master is the surrounding logic's view.
interface ides_word_align_if;
   import ides_align_pkg::*;

   logic [7:0] q_in;
   logic       align_start;
   logic       CALIB;
   logic [7:0] data_out;
   logic       data_valid;
   logic       locked;
   logic       error;
   logic [2:0] slip_count;

   modport slave (
      input  q_in, align_start,
      output CALIB, data_out, data_valid, locked, error, slip_count
   );

   modport master (
      output q_in, align_start,
      input  CALIB, data_out, data_valid, locked, error, slip_count
   );

endinterface

// File: rtl/ides_word_align.sv
// Word-alignment FSM for the IDES8 1:8 deserializer: bit-slips via CALIB until the
// training word is seen MATCH_COUNT times in a row. Optional auto-retry: WORD_ALIGN_AUTORETRY_EN.
module ides_word_align
   import ides_align_pkg::*;
#(
   parameter logic [7:0] TRAIN_PATTERN = TRAIN_PATTERN_DEF,
   parameter int         MATCH_COUNT   = 16,
   parameter int         SLIP_WAIT     = 4,
   parameter int         MAX_SLIPS     = 7
`ifdef WORD_ALIGN_AUTORETRY_EN
   ,
   parameter int         RETRY_DELAY   = 1024
`endif
) (
   input  logic             PCLK,
   input  logic             RESET,
   ides_word_align_if.slave bus
);

   localparam logic [2:0] IDLE   = ST_IDLE;
   localparam logic [2:0] WAIT   = ST_WAIT;
   localparam logic [2:0] CHECK  = ST_CHECK;
   localparam logic [2:0] SLIP   = ST_SLIP;
   localparam logic [2:0] LOCKED = ST_LOCKED;
   localparam logic [2:0] FAIL   = ST_FAIL;

   localparam logic [WAIT_CNT_W-1:0]    WAIT_LOAD   = WAIT_CNT_W'(SLIP_WAIT);
   localparam logic [MATCH_CNT_W-1:0]   MATCH_LAST  = MATCH_CNT_W'(MATCH_COUNT - 1);
   localparam logic [ATTEMPT_CNT_W-1:0] ATTEMPT_MAX = ATTEMPT_CNT_W'(MAX_SLIPS);

   logic [2:0]               state_r;
   logic [2:0]               state_nxt_s;
   logic [WAIT_CNT_W-1:0]    wait_cnt_r;
   logic [MATCH_CNT_W-1:0]   match_cnt_r;
   logic [ATTEMPT_CNT_W-1:0] attempts_r;
   logic [2:0]               slip_count_r;
   logic                     calib_r;
   logic [7:0]               data_out_r;
   logic                     data_valid_r;
   logic                     locked_r;
   logic                     error_r;
   logic                     pattern_hit_s;
   logic                     retry_fire_s;
   logic                     restart_s;

`ifdef WORD_ALIGN_AUTORETRY_EN
   localparam int RETRY_W = $clog2(RETRY_DELAY + 1);

   logic [RETRY_W-1:0] retry_cnt_r;

   assign retry_fire_s = (state_r == FAIL) && (retry_cnt_r <= RETRY_W'(1));

   // Retry dwell counter: loaded on FAIL entry, counts down while in FAIL.
   always_ff @(posedge PCLK) begin
      if (RESET) begin
         retry_cnt_r <= RETRY_W'(0);
      end else if ((state_nxt_s == FAIL) && (state_r != FAIL)) begin
         retry_cnt_r <= RETRY_W'(RETRY_DELAY);
      end else if ((state_r == FAIL) && (retry_cnt_r != RETRY_W'(0))) begin
         retry_cnt_r <= retry_cnt_r - RETRY_W'(1);
      end else begin
         retry_cnt_r <= retry_cnt_r;
      end
   end
`else
   assign retry_fire_s = 1'b0;
`endif

   assign pattern_hit_s = (bus.q_in == TRAIN_PATTERN);
   assign restart_s     = bus.align_start | retry_fire_s;

   // Next-state decode; a restart overrides every state, including SLIP.
   always_comb begin
      state_nxt_s = state_r;
      if (restart_s) begin
         state_nxt_s = WAIT;
      end else begin
         case (state_r)
            IDLE:    state_nxt_s = IDLE;
            WAIT: begin
               if (wait_cnt_r <= WAIT_CNT_W'(1)) state_nxt_s = CHECK;
               else                             state_nxt_s = WAIT;
            end
            CHECK: begin
               if (pattern_hit_s) begin
                  if (match_cnt_r == MATCH_LAST) state_nxt_s = LOCKED;
                  else                           state_nxt_s = CHECK;
               end else if (attempts_r == ATTEMPT_MAX) begin
                  state_nxt_s = FAIL;
               end else begin
                  state_nxt_s = SLIP;
               end
            end
            SLIP:    state_nxt_s = WAIT;
            LOCKED:  state_nxt_s = LOCKED;
            FAIL:    state_nxt_s = FAIL;
            default: state_nxt_s = IDLE;
         endcase
      end
   end

   // State register and search counters.
   always_ff @(posedge PCLK) begin
      if (RESET) begin
         state_r      <= IDLE;
         wait_cnt_r   <= WAIT_CNT_W'(0);
         match_cnt_r  <= MATCH_CNT_W'(0);
         attempts_r   <= ATTEMPT_CNT_W'(0);
         slip_count_r <= 3'd0;
      end else begin
         state_r <= state_nxt_s;
         // The slip pointer tracks the deserializer even when a restart lands on SLIP.
         if (state_r == SLIP) slip_count_r <= slip_count_r + 3'd1;
         else                 slip_count_r <= slip_count_r;
         if (restart_s) begin
            wait_cnt_r  <= WAIT_LOAD;
            match_cnt_r <= MATCH_CNT_W'(0);
            attempts_r  <= ATTEMPT_CNT_W'(0);
         end else begin
            case (state_r)
               WAIT: begin
                  if (wait_cnt_r != WAIT_CNT_W'(0)) wait_cnt_r <= wait_cnt_r - WAIT_CNT_W'(1);
                  else                             wait_cnt_r <= wait_cnt_r;
               end
               CHECK: begin
                  if (pattern_hit_s) match_cnt_r <= match_cnt_r + MATCH_CNT_W'(1);
                  else               match_cnt_r <= MATCH_CNT_W'(0);
               end
               SLIP: begin
                  attempts_r <= attempts_r + ATTEMPT_CNT_W'(1);
                  wait_cnt_r <= WAIT_LOAD;
               end
               default: begin
                  wait_cnt_r <= wait_cnt_r;
               end
            endcase
         end
      end
   end

   // Registered outputs decoded from the next state so they align with the state register.
   always_ff @(posedge PCLK) begin
      if (RESET) begin
         calib_r      <= 1'b0;
         data_out_r   <= 8'h00;
         data_valid_r <= 1'b0;
         locked_r     <= 1'b0;
         error_r      <= 1'b0;
      end else begin
         calib_r      <= (state_nxt_s == SLIP);
         data_out_r   <= bus.q_in;
         data_valid_r <= (state_nxt_s == LOCKED);
         locked_r     <= (state_nxt_s == LOCKED);
         error_r      <= (state_nxt_s == FAIL);
      end
   end

   assign bus.CALIB      = calib_r;
   assign bus.data_out   = data_out_r;
   assign bus.data_valid = data_valid_r;
   assign bus.locked     = locked_r;
   assign bus.error      = error_r;
   assign bus.slip_count = slip_count_r;

endmodule

// File: tb/tb_ides_word_align.sv
// Directed bench for ides_word_align with a behavioural IDES8 slip-pointer model.
// Define WORD_ALIGN_AUTORETRY_EN to exercise the auto-retry path.
module tb_ides_word_align;
   import ides_align_pkg::*;

   logic PCLK;
   logic RESET;
   ides_word_align_if bus ();

`ifdef WORD_ALIGN_AUTORETRY_EN
   ides_word_align #(.RETRY_DELAY(32)) dut (.PCLK(PCLK), .RESET(RESET), .bus(bus));
`else
   ides_word_align dut (.PCLK(PCLK), .RESET(RESET), .bus(bus));
`endif

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   int         n_total = 0;
   int         n_pass  = 0;
   int         n_fail  = 0;
   int         cycle   = 0;
   int         model_slips  = 0;
   int         model_offset = 0;
   logic       model_rot    = 1'b1;
   logic [7:0] const_word   = 8'h00;
   logic       calib_prev   = 1'b0;
   int         pulses       = 0;
   int         last_pulse   = -1;
   int         min_gap      = 1000;
   int         double_calib = 0;
   int         lat;
   logic       held;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One PCLK cycle: update the deserializer model, then sample and drive #1 after the edge.
   task automatic step();
      @(posedge PCLK);
      cycle++;
      if (RESET)           model_slips = 0;
      else if (calib_prev) model_slips = (model_slips + 1) % 8;
      #1;
      if (bus.CALIB) begin
         if (calib_prev) double_calib++;
         pulses++;
         if (last_pulse >= 0 && (cycle - last_pulse) < min_gap) min_gap = cycle - last_pulse;
         last_pulse = cycle;
      end
      calib_prev = bus.CALIB;
      if (model_rot) bus.q_in = rotl8(TRAIN_PATTERN_DEF, 3'((model_offset + model_slips) % 8));
      else           bus.q_in = const_word;
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      bus.align_start = 1'b0;
      step();
      step();
      RESET = 1'b0;
      pulses = 0;
      last_pulse = -1;
      min_gap = 1000;
   endtask

   task automatic pulse_start();
      bus.align_start = 1'b1;
      step();
      bus.align_start = 1'b0;
   endtask

   task automatic wait_done(input int limit, output int cycles);
      cycles = -1;
      for (int i = 1; i <= limit; i++) begin
         step();
         if (bus.locked || bus.error) begin
            cycles = i;
            break;
         end
      end
   endtask

   initial begin
      RESET = 1'b1;
      bus.q_in = 8'h00;
      bus.align_start = 1'b0;

      // Reset state
      step();
      step();
      chk("rst_calib", 32'(bus.CALIB), 32'd0);
      chk("rst_locked", 32'(bus.locked), 32'd0);
      chk("rst_error", 32'(bus.error), 32'd0);
      chk("rst_valid", 32'(bus.data_valid), 32'd0);
      chk("rst_data", 32'(bus.data_out), 32'd0);
      chk("rst_slip", 32'(bus.slip_count), 32'd0);

      // 1: already aligned stream
      model_rot = 1'b1; model_offset = 0;
      do_reset();
      pulse_start();
      wait_done(200, lat);
      chk("t1_lock_lat", 32'(lat), 32'd20);
      chk("t1_pulses", 32'(pulses), 32'd0);
      chk("t1_locked", 32'(bus.locked), 32'd1);
      chk("t1_valid", 32'(bus.data_valid), 32'd1);
      chk("t1_error", 32'(bus.error), 32'd0);
      bus.q_in = 8'hA5;
      step();
      chk("t1_data_a5", 32'(bus.data_out), 32'hA5);
      bus.q_in = 8'h3C;
      step();
      chk("t1_data_3c", 32'(bus.data_out), 32'h3C);
      chk("t1_valid_hold", 32'(bus.data_valid), 32'd1);

      // 2: misaligned by three positions
      model_offset = 5;
      do_reset();
      pulse_start();
      wait_done(500, lat);
      chk("t2_pulses", 32'(pulses), 32'd3);
      chk("t2_gap_ok", 32'(min_gap >= 5), 32'd1);
      chk("t2_slip", 32'(bus.slip_count), 32'd3);
      chk("t2_locked", 32'(bus.locked), 32'd1);

      // 3: no training pattern at any position
      model_rot = 1'b0; const_word = 8'h00;
      do_reset();
      pulse_start();
      wait_done(500, lat);
      chk("t3_error", 32'(bus.error), 32'd1);
      chk("t3_locked", 32'(bus.locked), 32'd0);
      chk("t3_valid", 32'(bus.data_valid), 32'd0);
      chk("t3_pulses", 32'(pulses), 32'd7);
      chk("t3_slip", 32'(bus.slip_count), 32'd7);
`ifdef WORD_ALIGN_AUTORETRY_EN
      // 6: auto-retry after 32 cycles in FAIL, then lock on a good stream
      lat = -1;
      for (int i = 1; i <= 100; i++) begin
         step();
         if (!bus.error) begin
            lat = i;
            break;
         end
      end
      chk("t6_retry_delay", 32'(lat), 32'd32);
      const_word = 8'hF0;
      wait_done(200, lat);
      chk("t6_relock_lat", 32'(lat), 32'd20);
      chk("t6_locked", 32'(bus.locked), 32'd1);
      chk("t6_error", 32'(bus.error), 32'd0);
`else
      held = 1'b1;
      for (int i = 0; i < 5000; i++) begin
         step();
         if (!bus.error || bus.locked) held = 1'b0;
      end
      chk("t3_error_sticky", 32'(held), 32'd1);
      chk("t3_pulses_after", 32'(pulses), 32'd7);
`endif

      // 4: corrupt word at match 10, then restart completes the 8-position cycle
      model_rot = 1'b1; model_offset = 0;
      do_reset();
      pulse_start();
      for (int i = 0; i < 14; i++) step();
      chk("t4_pre_pulses", 32'(pulses), 32'd0);
      bus.q_in = 8'h0F;
      step();
      for (int i = 0; i < 3; i++) step();
      chk("t4_one_pulse", 32'(pulses), 32'd1);
      chk("t4_slip1", 32'(bus.slip_count), 32'd1);
      chk("t4_unlocked", 32'(bus.locked), 32'd0);
      pulse_start();
      wait_done(500, lat);
      chk("t4_pulses", 32'(pulses), 32'd8);
      chk("t4_slip0", 32'(bus.slip_count), 32'd0);
      chk("t4_locked", 32'(bus.locked), 32'd1);

      // 5a: RESET during the SLIP cycle
      model_offset = 5;
      do_reset();
      pulse_start();
      held = 1'b0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (bus.CALIB) begin
            held = 1'b1;
            break;
         end
      end
      chk("t5_saw_slip", 32'(held), 32'd1);
      RESET = 1'b1;
      step();
      chk("t5_calib", 32'(bus.CALIB), 32'd0);
      chk("t5_slip", 32'(bus.slip_count), 32'd0);
      chk("t5_outs", 32'({bus.locked, bus.error, bus.data_valid}), 32'd0);
      chk("t5_data", 32'(bus.data_out), 32'd0);
      RESET = 1'b0;

      // 5b: align_start during CHECK restarts into WAIT, slip position kept
      model_offset = 7;
      do_reset();
      pulse_start();
      for (int i = 0; i < 15; i++) step();
      chk("t5_mid_slip", 32'(bus.slip_count), 32'd1);
      chk("t5_mid_locked", 32'(bus.locked), 32'd0);
      pulse_start();
      chk("t5_restart_slip", 32'(bus.slip_count), 32'd1);
      wait_done(200, lat);
      chk("t5_relock_lat", 32'(lat), 32'd20);
      chk("t5_pulses", 32'(pulses), 32'd1);
      chk("t5_final_slip", 32'(bus.slip_count), 32'd1);

      chk("calib_single", 32'(double_calib), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
